// File: rtl/bitwise_alu.sv
// Two-stage pipelined bitwise ALU with valid/ready handshakes on both sides
// and a wrapping count of completed output transfers.
module bitwise_alu #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 zero,
  output logic                 parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOTA = 3'd3;
  localparam logic [2:0] OP_NOTB = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  // Stage-1 registers: captured operands and opcode
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;

  logic             w_s2_en;
  logic             w_s1_en;
  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_parity;

  // Stage enables: a stage advances when empty or when its successor advances
  always_comb begin
    w_s2_en  = !out_valid || out_ready;
    w_s1_en  = !r_s1_valid || w_s2_en;
    in_ready = w_s1_en;
  end

  // Bitwise operation and flag derivation from stage-1 contents
  always_comb begin
    w_res = '0;
    case (r_s1_op)
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_NOTA: w_res = ~r_s1_a;
      OP_NOTB: w_res = ~r_s1_b;
      OP_NAND: w_res = ~(r_s1_a & r_s1_b);
      OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
      OP_XNOR: w_res = ~(r_s1_a ^ r_s1_b);
      default: w_res = '0;
    endcase
    w_zero   = (w_res == '0);
    w_parity = ^w_res;
  end

  // Stage 1: accept a new transaction whenever the stage can advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= a;
        r_s1_b  <= b;
        r_s1_op <= op;
      end
    end
  end

  // Stage 2: register result and flags; an empty stage 1 passes a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
    end else if (w_s2_en) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        result <= w_res;
        zero   <= w_zero;
        parity <= w_parity;
      end
    end
  end

  // Completed output handshakes, wrapping at 2^CNT_WIDTH
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (out_valid && out_ready) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule
